// File: rtl/decompressor_seq_ctrl.sv
// decompressor_seq_ctrl
//   Sequencing FSM for the decompressor datapath. It fetches one compressed
//   word per CPU request and detects the expansion token. A token emits two
//   decompressed words (data1, then the registered data2). A plain word
//   emits one. The FSM drives the PC, latch, mux and output-register
//   controls. It also arbitrates the conversion-table write port between
//   config writes and decode lookups.
//
//   Optional feature macro: DECOMP_PERF_CNT_EN
//     defined   -> saturating fetch_cnt / expand_cnt performance counters
//     undefined -> fetch_cnt / expand_cnt tied to 0, no counter flops
//
//   Every output is forced low while reset is asserted, so an abandoned
//   operation produces no strobe during the reset cycle.
module decompressor_seq_ctrl #(
    parameter int TIMEOUT_CYC = 15,   // FETCH cycles without mem_ack before abort (1..255)
    parameter int CNT_W       = 16    // performance counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_ready,
    input  logic             cpu_branch,
    input  logic             encode,
    input  logic             mem_ack,
    input  logic             tbl_wr_req,
    output logic             mem_req,
    output logic             pc_sel_cpu,
    output logic             pc_en,
    output logic             in_latch_en,
    output logic             tbl_sel,
    output logic             out_sel,
    output logic             out_latch_en,
    output logic             out2_en,
    output logic             tbl_we,
    output logic             instr_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] expand_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_HOLD,
        S_EMIT2,
        S_FLUSH
    } state_t;

    // The timeout counter starts at 0 on the first FETCH cycle, so the
    // abort fires when it reaches TIMEOUT_CYC-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state, state_nxt;
    logic       pending2, pending2_nxt;   // data2 still owed to the CPU
    logic       wr_last, wr_last_nxt;     // last IDLE arbitration went to the table write
    logic       sel_cpu, sel_cpu_nxt;     // the fetch in flight addresses PCcpu
    logic [7:0] tmo_cnt, tmo_cnt_nxt;     // FETCH cycles elapsed without mem_ack

    logic wr_grant;
    logic tmo_hit;

    // A table write wins in IDLE unless it won last time and the CPU is waiting.
    assign wr_grant = tbl_wr_req && !(cpu_req && wr_last);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    // State register and control flags
    // NOTE: clocked state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            pending2 <= 1'b0;
            wr_last  <= 1'b0;
            sel_cpu  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pending2 <= pending2_nxt;
            wr_last  <= wr_last_nxt;
            sel_cpu  <= sel_cpu_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
        end
    end

    // Next-state logic; a branch in FETCH/DECODE/HOLD/EMIT2 always goes to FLUSH
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        pending2_nxt = pending2;
        wr_last_nxt  = wr_last;
        sel_cpu_nxt  = sel_cpu;
        tmo_cnt_nxt  = '0;
        case (state)
            S_IDLE: begin
                if (wr_grant) begin
                    wr_last_nxt = 1'b1;
                end else if (cpu_req) begin
                    wr_last_nxt = 1'b0;
                    sel_cpu_nxt = cpu_branch;
                    state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cpu_branch) begin
                    state_nxt = S_FLUSH;
                end else if (mem_ack) begin
                    state_nxt = S_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                if (cpu_branch) begin
                    state_nxt = S_FLUSH;
                end else begin
                    pending2_nxt = encode;
                    state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cpu_branch) begin
                    state_nxt = S_FLUSH;
                end else if (cpu_ready) begin
                    if (pending2) begin
                        state_nxt = S_EMIT2;
                    end else begin
                        sel_cpu_nxt = 1'b0;
                        state_nxt   = cpu_req ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_EMIT2: begin
                pending2_nxt = 1'b0;
                state_nxt    = cpu_branch ? S_FLUSH : S_HOLD;
            end
            S_FLUSH: begin
                pending2_nxt = 1'b0;
                sel_cpu_nxt  = 1'b1;
                state_nxt    = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Mealy output decode; all strobes are single-cycle and gated off during reset
    always_comb begin
        mem_req      = 1'b0;
        pc_sel_cpu   = 1'b0;
        pc_en        = 1'b0;
        in_latch_en  = 1'b0;
        tbl_sel      = 1'b0;
        out_sel      = 1'b0;
        out_latch_en = 1'b0;
        out2_en      = 1'b0;
        tbl_we       = 1'b0;
        instr_valid  = 1'b0;
        busy         = 1'b0;
        timeout_err  = 1'b0;
        if (reset) begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (wr_grant) begin
                        tbl_we = 1'b1;
                    end else if (cpu_req) begin
                        mem_req    = 1'b1;
                        pc_sel_cpu = cpu_branch;
                    end
                end
                S_FETCH: begin
                    mem_req    = 1'b1;
                    pc_sel_cpu = sel_cpu;
                    if (!cpu_branch) begin
                        if (mem_ack) begin
                            in_latch_en = 1'b1;
                        end else if (tmo_hit) begin
                            timeout_err = 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (!cpu_branch) begin
                        tbl_sel      = encode;
                        out_latch_en = 1'b1;
                        out2_en      = encode;
                    end
                end
                S_HOLD: begin
                    instr_valid = 1'b1;
                    // The PC advances only once the last word of this fetch is accepted.
                    pc_en = !cpu_branch && cpu_ready && !pending2;
                end
                S_EMIT2: begin
                    if (!cpu_branch) begin
                        out_sel      = 1'b1;
                        out_latch_en = 1'b1;
                    end
                end
                S_FLUSH: begin
                    pc_sel_cpu = 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

`ifdef DECOMP_PERF_CNT_EN
    // Saturating performance counters: accepted fetches and expanded tokens
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt  <= '0;
            expand_cnt <= '0;
        end else begin
            if (in_latch_en && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (out2_en && (expand_cnt != '1)) begin
                expand_cnt <= expand_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign fetch_cnt  = '0;
    assign expand_cnt = '0;
`endif

endmodule

// File: tb/tb_decompressor_seq_ctrl.sv
// Self-checking bench for decompressor_seq_ctrl.
// Inputs change on the falling edge and outputs are sampled 1 ns later, well
// away from the rising edge. Directed steps cover reset, the plain and token
// paths, flush, timeout, write arbitration and a reset during EMIT2. A
// randomized phase follows. It is checked against a transaction model that
// tracks words, owed beats and arbitration history.
module tb_decompressor_seq_ctrl;

    localparam int TMO = 15;
    localparam int CW  = 16;
`ifdef DECOMP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk, reset;
    logic cpu_req, cpu_ready, cpu_branch, encode, mem_ack, tbl_wr_req;
    logic mem_req, pc_sel_cpu, pc_en, in_latch_en, tbl_sel, out_sel;
    logic out_latch_en, out2_en, tbl_we, instr_valid, busy, timeout_err;
    logic [CW-1:0] fetch_cnt, expand_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state for the random phase
    bit m_waiting;     // a fetch is outstanding, waiting for mem_ack
    bit m_dec_pend;    // the word just latched is being decoded this cycle
    bit m_emit_pend;   // data2 is being loaded this cycle
    bit m_last_wr;     // previous IDLE arbitration granted the table write
    int m_beats;       // words still owed to the CPU for the current fetch
    int m_words;
    int m_tokens;
    int m_ack_wait;

    decompressor_seq_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_ready    (cpu_ready),
        .cpu_branch   (cpu_branch),
        .encode       (encode),
        .mem_ack      (mem_ack),
        .tbl_wr_req   (tbl_wr_req),
        .mem_req      (mem_req),
        .pc_sel_cpu   (pc_sel_cpu),
        .pc_en        (pc_en),
        .in_latch_en  (in_latch_en),
        .tbl_sel      (tbl_sel),
        .out_sel      (out_sel),
        .out_latch_en (out_latch_en),
        .out2_en      (out2_en),
        .tbl_we       (tbl_we),
        .instr_valid  (instr_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .fetch_cnt    (fetch_cnt),
        .expand_cnt   (expand_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_ready = 0; cpu_branch = 0;
        encode = 0; mem_ack = 0; tbl_wr_req = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [11:0] outs();
        return {mem_req, pc_sel_cpu, pc_en, in_latch_en, tbl_sel, out_sel,
                out_latch_en, out2_en, tbl_we, instr_valid, busy, timeout_err};
    endfunction

    function automatic int cnt_exp(input int n);
        return PERF ? n : 0;
    endfunction

    // One random (or draining) cycle: drive inputs, compare against the model, advance it.
    task automatic rnd_cycle(input bit drain);
        bit active, grant;
        active = m_waiting || m_dec_pend || m_emit_pend || (m_beats > 0);
        cpu_branch = 0;
        encode     = 1'($urandom_range(0, 1));
        if (drain) begin
            cpu_req = 0; tbl_wr_req = 0; cpu_ready = 1;
            mem_ack = 1;
        end else begin
            cpu_req    = ($urandom_range(0, 3) != 0);
            tbl_wr_req = ($urandom_range(0, 2) == 0);
            cpu_ready  = 1'($urandom_range(0, 1));
            if (m_waiting) mem_ack = (m_ack_wait >= 8) || ($urandom_range(0, 2) == 0);
            else           mem_ack = ($urandom_range(0, 4) == 0);
        end
        settle();
        chk("r_busy", busy, active);
        chk("r_timeout", timeout_err, 0);
        if (!active) begin
            grant = tbl_wr_req && !(cpu_req && m_last_wr);
            chk("r_tbl_we_idle", tbl_we, grant);
            chk("r_mem_req_idle", mem_req, cpu_req && !grant);
            if (grant) begin
                m_last_wr = 1;
            end else if (cpu_req) begin
                m_last_wr = 0; m_waiting = 1; m_ack_wait = 0;
            end
        end else begin
            chk("r_tbl_we_busy", tbl_we, 0);
            if (m_waiting) begin
                chk("r_mem_req_fetch", mem_req, 1);
                chk("r_in_latch", in_latch_en, mem_ack);
                if (mem_ack) begin
                    m_waiting = 0; m_dec_pend = 1; m_words++;
                end else begin
                    m_ack_wait++;
                end
            end else if (m_dec_pend) begin
                chk("r_dec_latch", out_latch_en, 1);
                chk("r_dec_tbl_sel", tbl_sel, encode);
                chk("r_dec_out2_en", out2_en, encode);
                chk("r_dec_out_sel", out_sel, 0);
                chk("r_dec_valid", instr_valid, 0);
                m_dec_pend = 0;
                m_beats    = encode ? 2 : 1;
                m_tokens  += int'(encode);
            end else if (m_emit_pend) begin
                chk("r_emit_valid", instr_valid, 0);
                chk("r_emit_latch", out_latch_en, 1);
                chk("r_emit_out_sel", out_sel, 1);
                chk("r_emit_pc_en", pc_en, 0);
                m_emit_pend = 0;
            end else begin
                chk("r_hold_valid", instr_valid, 1);
                if (cpu_ready) begin
                    m_beats--;
                    chk("r_hold_pc_en", pc_en, m_beats == 0);
                    if (m_beats > 0) begin
                        m_emit_pend = 1;
                    end else if (cpu_req) begin
                        m_waiting = 1; m_ack_wait = 0;
                    end
                end else begin
                    chk("r_hold_pc_en_wait", pc_en, 0);
                end
            end
        end
        tick();
    endtask

    initial begin
        // ---------------- reset ----------------
        reset = 0; idle_in();
        cpu_req = 1; tbl_wr_req = 1; cpu_branch = 1; mem_ack = 1;
        tick(); settle();
        chk("reset_outs", outs(), 0);
        chk("reset_fetch_cnt", fetch_cnt, 0);
        chk("reset_expand_cnt", expand_cnt, 0);
        tick();
        reset = 1; idle_in(); settle();
        chk("idle_outs", outs(), 0);
        tick();

        // ---------------- 1: plain word, zero-wait ack ----------------
        cpu_req = 1; cpu_ready = 1; settle();
        chk("t1_launch_mem_req", mem_req, 1);
        chk("t1_launch_sel", pc_sel_cpu, 0);
        chk("t1_launch_busy", busy, 0);
        tick(); cpu_req = 0; mem_ack = 1; settle();
        chk("t1_fetch_mem_req", mem_req, 1);
        chk("t1_fetch_in_latch", in_latch_en, 1);
        chk("t1_fetch_busy", busy, 1);
        tick(); mem_ack = 0; encode = 0; settle();
        chk("t1_dec_out_latch", out_latch_en, 1);
        chk("t1_dec_sels", {tbl_sel, out_sel, out2_en}, 0);
        chk("t1_dec_valid", instr_valid, 0);
        tick(); settle();
        chk("t1_hold_valid_3cyc", instr_valid, 1);
        chk("t1_hold_pc_en", pc_en, 1);
        tick(); cpu_ready = 0; settle();
        chk("t1_end_outs", outs(), 0);
        chk("t1_fetch_cnt", fetch_cnt, cnt_exp(1));
        tick();

        // ---------------- 2: token word, two beats ----------------
        cpu_req = 1; cpu_ready = 1; settle();
        chk("t2_launch", mem_req, 1);
        tick(); cpu_req = 0; mem_ack = 1; settle();
        chk("t2_in_latch", in_latch_en, 1);
        tick(); mem_ack = 0; encode = 1; settle();
        chk("t2_dec_tbl_sel", tbl_sel, 1);
        chk("t2_dec_out2_en", out2_en, 1);
        chk("t2_dec_out_latch_sel", {out_latch_en, out_sel}, 2'b10);
        tick(); encode = 0; settle();
        chk("t2_beat1_valid", instr_valid, 1);
        chk("t2_beat1_pc_en", pc_en, 0);
        tick(); settle();
        chk("t2_emit_valid", instr_valid, 0);
        chk("t2_emit_latch_sel", {out_latch_en, out_sel}, 2'b11);
        chk("t2_emit_pc_en", pc_en, 0);
        tick(); settle();
        chk("t2_beat2_valid", instr_valid, 1);
        chk("t2_beat2_pc_en", pc_en, 1);
        tick(); cpu_ready = 0; settle();
        chk("t2_end_busy", busy, 0);
        chk("t2_expand_cnt", expand_cnt, cnt_exp(1));
        chk("t2_fetch_cnt", fetch_cnt, cnt_exp(2));
        tick();

        // ---------------- 3: branch in HOLD with pending data2 ----------------
        cpu_req = 1; settle();
        tick(); cpu_req = 0; mem_ack = 1; settle();
        tick(); mem_ack = 0; encode = 1; settle();
        chk("t3_dec_out2_en", out2_en, 1);
        tick(); encode = 0; cpu_ready = 1; cpu_branch = 1; settle();
        chk("t3_branch_pc_en", pc_en, 0);
        tick(); cpu_branch = 0; mem_ack = 1; settle();
        chk("t3_flush_valid", instr_valid, 0);
        chk("t3_flush_strobes", {pc_en, in_latch_en, out_latch_en, mem_req}, 0);
        chk("t3_flush_busy", busy, 1);
        tick(); settle();
        chk("t3_refetch_mem_req", mem_req, 1);
        chk("t3_refetch_pc_sel_cpu", pc_sel_cpu, 1);
        chk("t3_refetch_in_latch", in_latch_en, 1);
        tick(); mem_ack = 0; encode = 0; settle();
        chk("t3_dec2_plain", {out_latch_en, out_sel, out2_en}, 3'b100);
        tick(); settle();
        chk("t3_hold_pc_en", pc_en, 1);
        tick(); cpu_ready = 0; settle();
        chk("t3_end_busy", busy, 0);
        chk("t3_fetch_cnt", fetch_cnt, cnt_exp(4));
        chk("t3_expand_cnt", expand_cnt, cnt_exp(2));
        tick();

        // ---------------- 4: mem_ack never arrives ----------------
        cpu_req = 1; settle();
        tick(); cpu_req = 0;
        for (int i = 1; i <= TMO; i++) begin
            settle();
            chk("t4_fetch_mem_req", mem_req, 1);
            chk("t4_timeout_err", timeout_err, i == TMO);
            tick();
        end
        settle();
        chk("t4_after_busy", busy, 0);
        chk("t4_after_pulse", timeout_err, 0);
        tick();

        // ---------------- 5: write vs request arbitration ----------------
        tbl_wr_req = 1; cpu_req = 1; cpu_ready = 1; settle();
        chk("t5_grant1_we", tbl_we, 1);
        chk("t5_grant1_mem_req", mem_req, 0);
        tick(); settle();
        chk("t5_req1_we", tbl_we, 0);
        chk("t5_req1_mem_req", mem_req, 1);
        tick(); mem_ack = 1; settle();
        chk("t5_fetch_we", tbl_we, 0);
        tick(); mem_ack = 0; settle();
        chk("t5_dec_we", tbl_we, 0);
        tick(); cpu_req = 0; settle();
        chk("t5_hold_pc_en", pc_en, 1);
        chk("t5_hold_we", tbl_we, 0);
        tick(); cpu_req = 1; settle();
        chk("t5_grant2_we", tbl_we, 1);
        tick(); settle();
        chk("t5_req2_we", tbl_we, 0);
        chk("t5_req2_mem_req", mem_req, 1);
        tick(); mem_ack = 1; settle();
        tick(); mem_ack = 0; settle();
        tick(); cpu_req = 0; settle();
        chk("t5_hold2_pc_en", pc_en, 1);
        tick(); settle();
        chk("t5_wr_only_a", tbl_we, 1);
        tick(); settle();
        chk("t5_wr_only_b", tbl_we, 1);
        tick(); idle_in(); settle();
        chk("t5_end_busy", busy, 0);
        chk("t5_fetch_cnt", fetch_cnt, cnt_exp(6));
        tick();

        // ---------------- 6: reset during EMIT2 ----------------
        cpu_req = 1; cpu_ready = 1; settle();
        tick(); cpu_req = 0; mem_ack = 1; settle();
        tick(); mem_ack = 0; encode = 1; settle();
        tick(); encode = 0; settle();
        chk("t6_beat1_valid", instr_valid, 1);
        chk("t6_pre_fetch_cnt", fetch_cnt, cnt_exp(7));
        chk("t6_pre_expand_cnt", expand_cnt, cnt_exp(3));
        tick(); reset = 0; settle();
        chk("t6_in_reset_outs", outs(), 0);
        tick(); reset = 1; idle_in(); settle();
        chk("t6_after_outs", outs(), 0);
        chk("t6_after_fetch_cnt", fetch_cnt, 0);
        chk("t6_after_expand_cnt", expand_cnt, 0);
        tick(); settle();
        chk("t6_no_late_pulse", outs(), 0);
        tick();

        // ---------------- randomized phase ----------------
        m_waiting = 0; m_dec_pend = 0; m_emit_pend = 0; m_last_wr = 0;
        m_beats = 0; m_words = 0; m_tokens = 0; m_ack_wait = 0;
        for (int c = 0; c < 400; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 20; c++) begin
            if (m_waiting || m_dec_pend || m_emit_pend || (m_beats > 0)) rnd_cycle(1'b1);
        end
        idle_in(); settle();
        chk("rnd_drained_busy", busy, 0);
        chk("rnd_fetch_cnt", fetch_cnt, cnt_exp(m_words));
        chk("rnd_expand_cnt", expand_cnt, cnt_exp(m_tokens));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
